// File: rtl/a5_xor_packer.sv
// A5/1 keystream consumer: drops the mixing-phase bits of each frame, packs the rest
// MSB-first into W-bit words and XORs each word with one plaintext word.
module a5_xor_packer #(
  parameter int W       = 8,
  parameter int DISCARD = 100
) (
  input  logic         clk,
  input  logic         rest_n,
  input  logic         start,
  input  logic         ks_bit,
  input  logic         ks_valid,
  output logic         ks_ready,
  input  logic [W-1:0] pt_data,
  input  logic         pt_valid,
  input  logic         pt_last,
  output logic         pt_ready,
  output logic [W-1:0] ct_data,
  output logic         ct_valid,
  output logic         ct_last,
  input  logic         ct_ready,
  output logic         busy
);

  localparam int BW = $clog2(W + 1);
  localparam int DW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam logic [BW-1:0] BIT_FULL = BW'(W);
  localparam logic [DW-1:0] DISC_END = DW'(DISCARD);

  typedef enum logic [1:0] {S_IDLE, S_DISCARD, S_RUN} state_e;

  // With no mixing phase a new frame goes straight to packing.
  localparam state_e START_STATE = (DISCARD > 0) ? S_DISCARD : S_RUN;

  state_e        state_q, state_d;
  logic [DW-1:0] discCnt_q, discCnt_d;
  logic [BW-1:0] bitCnt_q, bitCnt_d;
  logic [W-1:0]  key_q, key_d;
  logic [W-1:0]  ctData_q, ctData_d;
  logic          ctValid_q, ctValid_d;
  logic          ctLast_q, ctLast_d;

  logic ksFire, ptFire, ctFire;

  assign ksFire = ks_valid && ks_ready;
  assign ptFire = pt_valid && pt_ready;
  assign ctFire = ctValid_q && ct_ready;

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q   <= S_IDLE;
      discCnt_q <= '0;
      bitCnt_q  <= '0;
      key_q     <= '0;
      ctData_q  <= '0;
      ctValid_q <= 1'b0;
      ctLast_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      discCnt_q <= discCnt_d;
      bitCnt_q  <= bitCnt_d;
      key_q     <= key_d;
      ctData_q  <= ctData_d;
      ctValid_q <= ctValid_d;
      ctLast_q  <= ctLast_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    discCnt_d = discCnt_q;
    bitCnt_d  = bitCnt_q;
    key_d     = key_q;
    ctData_d  = ctData_q;
    ctValid_d = ctValid_q;
    ctLast_d  = ctLast_q;

    if (ctFire && !ptFire) begin
      ctValid_d = 1'b0;
    end

    // start aborts everything, including an undelivered ciphertext word.
    if (start) begin
      state_d   = START_STATE;
      discCnt_d = '0;
      bitCnt_d  = '0;
      key_d     = '0;
      ctValid_d = 1'b0;
    end else begin
      case (state_q)
        S_DISCARD: begin
          if (ksFire) begin
            discCnt_d = discCnt_q + DW'(1);
            if (discCnt_d == DISC_END) begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (ksFire) begin
            key_d    = W'({key_q, ks_bit});
            bitCnt_d = bitCnt_q + BW'(1);
          end
          if (ptFire) begin
            ctData_d  = pt_data ^ key_q;
            ctLast_d  = pt_last;
            ctValid_d = 1'b1;
            bitCnt_d  = '0;
            if (pt_last) begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ready signals look only at state, counters, ct_ready and start.
  always_comb begin
    ks_ready = 1'b0;
    pt_ready = 1'b0;
    case (state_q)
      S_DISCARD: ks_ready = 1'b1;
      S_RUN: begin
        ks_ready = (bitCnt_q < BIT_FULL);
        pt_ready = (bitCnt_q == BIT_FULL) && (!ctValid_q || ct_ready) && !start;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ct_data  = ctData_q;
  assign ct_valid = ctValid_q;
  assign ct_last  = ctLast_q;

endmodule

// File: tb/tb_a5_xor_packer.sv
// Self-checking bench for a5_xor_packer: directed scenarios plus random frames
// checked against a frame-level model built from keystream bit indices.
module tb_a5_xor_packer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rest_n;
  logic         start;
  logic         ks_bit;
  logic         ks_valid;
  logic         ks_ready;
  logic [W-1:0] pt_data;
  logic         pt_valid;
  logic         pt_last;
  logic         pt_ready;
  logic [W-1:0] ct_data;
  logic         ct_valid;
  logic         ct_last;
  logic         ct_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Model: every consumed keystream bit of the frame, in arrival order.
  bit           mInFrame;
  int           mKsCount;
  int           mWords;
  bit           mValid;
  logic [W-1:0] mCtData;
  bit           mCtLast;
  bit           mBits[$];

  bit           lastKsFire;
  bit           lastPtFire;
  int           dutKsFires;
  logic [W-1:0] k1, k2, p2;
  int           plan;
  int           guard;

  always #5 clk = ~clk;

  a5_xor_packer #(.W(W), .DISCARD(D)) dut (
    .clk      (clk),
    .rest_n   (rest_n),
    .start    (start),
    .ks_bit   (ks_bit),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_last  (pt_last),
    .pt_ready (pt_ready),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_last  (ct_last),
    .ct_ready (ct_ready),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word k uses frame bits D+W*k .. D+W*k+W-1, first bit most significant.
  function automatic logic [W-1:0] modelKey(input int k);
    logic [W-1:0] key;
    key = '0;
    for (int i = 0; i < W; i++) key = {key[W-2:0], mBits[D + W*k + i]};
    return key;
  endfunction

  task automatic modelReset();
    mInFrame = 1'b0;
    mKsCount = 0;
    mWords   = 0;
    mValid   = 1'b0;
    mCtData  = '0;
    mCtLast  = 1'b0;
    mBits.delete();
  endtask

  task automatic applyStimulus(input bit st, input bit kb, input bit kv, input logic [W-1:0] pd,
                               input bit pv, input bit pl, input bit cr);
    bit expKs, expPt, ksF, ptF, ctF;
    int target;
    @(negedge clk);
    start    = st;
    ks_bit   = kb;
    ks_valid = kv;
    pt_data  = pd;
    pt_valid = pv;
    pt_last  = pl;
    ct_ready = cr;
    #2;
    target = D + W * (mWords + 1);
    expKs  = mInFrame && (mKsCount < target);
    expPt  = mInFrame && (mKsCount == target) && (!mValid || cr) && !st;
    checkOutput("ks_ready", ks_ready, expKs);
    checkOutput("pt_ready", pt_ready, expPt);
    checkOutput("ct_valid", ct_valid, mValid);
    checkOutput("busy", busy, mInFrame);
    if (mValid) begin
      checkOutput("ct_data", ct_data, mCtData);
      checkOutput("ct_last", ct_last, mCtLast);
    end
    if (kv && ks_ready) dutKsFires++;
    ksF = kv && expKs && !st;
    ptF = pv && expPt;
    ctF = mValid && cr;
    lastKsFire = ksF;
    lastPtFire = ptF;
    if (st) begin
      mInFrame = 1'b1;
      mKsCount = 0;
      mWords   = 0;
      mValid   = 1'b0;
      mBits.delete();
    end else begin
      if (ctF && !ptF) mValid = 1'b0;
      if (ksF) begin
        mBits.push_back(kb);
        mKsCount++;
      end
      if (ptF) begin
        mCtData = pd ^ modelKey(mWords);
        mCtLast = pl;
        mValid  = 1'b1;
        mWords++;
        if (pl) mInFrame = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit cr);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, cr);
  endtask

  task automatic feedBits(input logic [31:0] bits, input int n, input bit cr);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin
        applyStimulus(1'b0, bits[n-1-i], 1'b1, '0, 1'b0, 1'b0, cr);
        g++;
      end while (!lastKsFire && g < 20);
      if (!lastKsFire) checkOutput("feedTimeout", ks_ready, 1);
    end
  endtask

  task automatic sendWord(input logic [W-1:0] pd, input bit pl, input bit cr);
    int g;
    g = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0, pd, 1'b1, pl, cr);
      g++;
    end while (!lastPtFire && g < 20);
    if (!lastPtFire) checkOutput("sendTimeout", pt_ready, 1);
  endtask

  task automatic runBitOrderFrame(input bit last);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    dutKsFires = 0;
    feedBits(32'hF, 4, 1'b1);
    feedBits(32'hB1, 8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ksFiresBeforePt", dutKsFires, 12);
    checkOutput("ptReadyAfterKey", pt_ready, 1);
    sendWord(8'h00, last, 1'b0);
    idle(1'b0);
    checkOutput("bitOrderData", ct_data, 8'hB1);
    checkOutput("bitOrderValid", ct_valid, 1);
  endtask

  initial begin
    rest_n = 1'b0; start = 1'b0; ks_bit = 1'b0; ks_valid = 1'b0;
    pt_data = '0; pt_valid = 1'b0; pt_last = 1'b0; ct_ready = 1'b0;
    modelReset();
    dutKsFires = 0;

    repeat (2) idle(1'b0);
    checkOutput("rstCtData", ct_data, 0);
    checkOutput("rstCtLast", ct_last, 0);
    rest_n = 1'b1;

    runBitOrderFrame(1'b0);

    // Backpressure: hold 0xA5 while the next key word fills.
    idle(1'b1);
    k1 = W'($urandom);
    feedBits(32'(k1), 8, 1'b1);
    sendWord(k1 ^ 8'hA5, 1'b0, 1'b0);
    k2 = W'($urandom);
    p2 = W'($urandom);
    feedBits(32'(k2), 8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, p2, 1'b1, 1'b0, 1'b0);
    checkOutput("bpPtReady", pt_ready, 0);
    checkOutput("bpHold", ct_data, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, p2, 1'b1, 1'b0, 1'b1);
    checkOutput("bpPtFire", pt_ready, 1);
    idle(1'b0);
    checkOutput("bpNewWord", ct_data, p2 ^ k2);
    checkOutput("bpNewValid", ct_valid, 1);

    // Frame end.
    feedBits(32'hFF, 8, 1'b1);
    sendWord(8'h3C, 1'b1, 1'b1);
    idle(1'b0);
    checkOutput("endData", ct_data, 8'hC3);
    checkOutput("endLast", ct_last, 1);
    checkOutput("endBusy", busy, 0);
    checkOutput("endKsReady", ks_ready, 0);
    idle(1'b1);

    // Restart mid-RUN with a pending word and a partly filled key.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    feedBits(32'hF, 4, 1'b1);
    feedBits(32'h12, 8, 1'b1);
    sendWord(8'h77, 1'b0, 1'b0);
    feedBits(32'h15, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    dutKsFires = 0;
    idle(1'b0);
    checkOutput("rsCtValid", ct_valid, 0);
    checkOutput("rsBusy", busy, 1);
    checkOutput("rsKsReady", ks_ready, 1);
    feedBits(32'hF, 4, 1'b1);
    feedBits(32'h00, 8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rsKsFires", dutKsFires, 12);
    checkOutput("rsPtReady", pt_ready, 1);
    sendWord(8'h5A, 1'b1, 1'b1);
    idle(1'b0);
    checkOutput("discardData", ct_data, 8'h5A);
    idle(1'b1);

    // Asynchronous reset between clock edges, mid-RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    feedBits(32'hF, 4, 1'b1);
    feedBits(32'h5, 3, 1'b1);
    #1 rest_n = 1'b0;
    #1;
    checkOutput("arKsReady", ks_ready, 0);
    checkOutput("arPtReady", pt_ready, 0);
    checkOutput("arCtValid", ct_valid, 0);
    checkOutput("arCtData", ct_data, 0);
    checkOutput("arCtLast", ct_last, 0);
    checkOutput("arBusy", busy, 0);
    modelReset();
    idle(1'b1);
    rest_n = 1'b1;
    runBitOrderFrame(1'b1);
    idle(1'b1);

    // Random frames with random handshakes and occasional aborts.
    for (int f = 0; f < 20; f++) begin
      plan = $urandom_range(1, 5);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while ((mInFrame || mValid) && guard < 3000) begin
        applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                      W'($urandom), ($urandom_range(0, 2) != 0), (mWords == plan - 1),
                      ($urandom_range(0, 3) != 0));
        guard++;
      end
      checkOutput("frameDone", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
